// File: rtl/regfile_writeback_arbiter_if.sv
// Writeback bus between the ALU/load producers, the issue stage and the register file write port.
// Defining WB_FORWARD_EN adds the decode-stage bypass address and hit/data signals.
interface regfile_writeback_arbiter_if #(
    parameter int XLEN = 32,
    parameter int NREG = 32,
    parameter int AW   = 5
);
    logic            alu_valid;
    logic [AW-1:0]   alu_rd;
    logic [XLEN-1:0] alu_data;
    logic            ld_valid;
    logic            ld_ready;
    logic [AW-1:0]   ld_rd;
    logic [XLEN-1:0] ld_data;
    logic            iss_valid;
    logic [AW-1:0]   iss_rd;
    logic [NREG-1:0] busy;
    logic            we;
    logic [AW-1:0]   wrAddr;
    logic [XLEN-1:0] wrData;
`ifdef WB_FORWARD_EN
    logic [AW-1:0]   fwd_addr1;
    logic [AW-1:0]   fwd_addr2;
    logic            fwd_hit1;
    logic            fwd_hit2;
    logic [XLEN-1:0] fwd_data1;
    logic [XLEN-1:0] fwd_data2;
`endif

    modport master (
        output alu_valid, alu_rd, alu_data, ld_valid, ld_rd, ld_data, iss_valid, iss_rd,
`ifdef WB_FORWARD_EN
        output fwd_addr1, fwd_addr2,
        input  fwd_hit1, fwd_hit2, fwd_data1, fwd_data2,
`endif
        input  ld_ready, busy, we, wrAddr, wrData
    );

    modport slave (
        input  alu_valid, alu_rd, alu_data, ld_valid, ld_rd, ld_data, iss_valid, iss_rd,
`ifdef WB_FORWARD_EN
        input  fwd_addr1, fwd_addr2,
        output fwd_hit1, fwd_hit2, fwd_data1, fwd_data2,
`endif
        output ld_ready, busy, we, wrAddr, wrData
    );
endinterface

// File: rtl/regfile_writeback_arbiter.sv
// Writeback arbiter: ALU results beat queued load results onto the single register-file write port,
// and a pending-write scoreboard is kept for hazard detection. Optional bypass: WB_FORWARD_EN.
module regfile_writeback_arbiter #(
    parameter int XLEN     = 32,
    parameter int NREG     = 32,
    parameter int AW       = 5,
    parameter int LD_DEPTH = 2
) (
    input logic                      clk,
    input logic                      rst,
    regfile_writeback_arbiter_if.slave wb
);
    localparam int PW = (LD_DEPTH > 1) ? $clog2(LD_DEPTH) : 1;
    localparam int CW = PW + 1;

    typedef enum logic [1:0] {IDLE, SEL_ALU, SEL_LD} sel_e;

    logic [AW-1:0]   fifoRd   [LD_DEPTH];
    logic [XLEN-1:0] fifoData [LD_DEPTH];
    logic [PW-1:0]   rdPtr, wrPtr;
    logic [CW-1:0]   count;

    sel_e            sel;
    logic            push, pop, selWrite;
    logic [AW-1:0]   selRd;
    logic [XLEN-1:0] selData;
    logic [NREG-1:0] busyQ, busyNext;
    logic            weQ;
    logic [AW-1:0]   wrAddrQ;
    logic [XLEN-1:0] wrDataQ;

    assign wb.ld_ready = (count < CW'(LD_DEPTH));
    assign push        = wb.ld_valid && wb.ld_ready;
    assign pop         = (sel == SEL_LD);
    // x0 results are still consumed, they just never raise we or touch the scoreboard
    assign selWrite    = (sel != IDLE) && (selRd != '0);

    always_comb begin
        sel     = IDLE;
        selRd   = wb.alu_rd;
        selData = wb.alu_data;
        if (wb.alu_valid) begin
            sel = SEL_ALU;
        end else if (count != '0) begin
            sel     = SEL_LD;
            selRd   = fifoRd[rdPtr];
            selData = fifoData[rdPtr];
        end
    end

    // Clear before set so an issue landing on the same edge as the retiring write keeps the bit
    always_comb begin
        busyNext = busyQ;
        if (selWrite)
            busyNext[selRd] = 1'b0;
        if (wb.iss_valid && wb.iss_rd != '0)
            busyNext[wb.iss_rd] = 1'b1;
        busyNext[0] = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (push) begin
            fifoRd[wrPtr]   <= wb.ld_rd;
            fifoData[wrPtr] <= wb.ld_data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rdPtr   <= '0;
            wrPtr   <= '0;
            count   <= '0;
            busyQ   <= '0;
            weQ     <= 1'b0;
            wrAddrQ <= '0;
            wrDataQ <= '0;
        end else begin
            if (push)
                wrPtr <= wrPtr + 1'b1;
            if (pop)
                rdPtr <= rdPtr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
            busyQ <= busyNext;
            weQ   <= selWrite;
            if (sel != IDLE) begin
                wrAddrQ <= selRd;
                wrDataQ <= selData;
            end
        end
    end

    assign wb.busy   = busyQ;
    assign wb.we     = weQ;
    assign wb.wrAddr = wrAddrQ;
    assign wb.wrData = wrDataQ;

`ifdef WB_FORWARD_EN
    assign wb.fwd_hit1  = weQ && (wrAddrQ == wb.fwd_addr1) && (wb.fwd_addr1 != '0);
    assign wb.fwd_hit2  = weQ && (wrAddrQ == wb.fwd_addr2) && (wb.fwd_addr2 != '0);
    assign wb.fwd_data1 = wrDataQ;
    assign wb.fwd_data2 = wrDataQ;
`endif
endmodule

// File: doc/regfile_writeback_arbiter.md
Name: regfile_writeback_arbiter

Overview:
Writeback-side producer for the RISC-V register file. It takes results from the single-cycle ALU path and the multi-cycle load path, and arbitrates between them. It drives the file's single write port (we/wrAddr/wrData) from registered outputs. It also keeps a per-register pending scoreboard for the hazard logic.

Parameters:
XLEN, 32, data width of results and wrData
NREG, 32, number of architectural registers
AW, 5, register address width (log2 NREG)
LD_DEPTH, 2, load-result FIFO depth (power of two, >=2)

Ports:
clk  in  1  clock, rising edge
rst  in  1  reset, asynchronous, active-high
alu_valid  in  1  ALU result valid this cycle; no backpressure
alu_rd  in  AW  ALU destination register
alu_data  in  XLEN  ALU result
ld_valid  in  1  load result offered
ld_ready  out  1  load result accepted when ld_valid && ld_ready
ld_rd  in  AW  load destination register
ld_data  in  XLEN  load result
iss_valid  in  1  instruction issued that will write iss_rd
iss_rd  in  AW  issued destination register
busy  out  NREG  scoreboard; bit r=1 means a write to r is pending
we  out  1  register file write enable (registered)
wrAddr  out  AW  register file write address (registered)
wrData  out  XLEN  register file write data (registered)

Behaviour:
- Reset (async, rst=1): we=0, wrAddr=0, wrData=0, busy=0, FIFO emptied (rd/wr pointers and count=0). ld_ready=1 once rst deasserts.
- Reset mid-operation discards all FIFO contents and pending busy bits immediately; no write is issued for discarded entries.
- Load FIFO:
  - Push on ld_valid && ld_ready.
  - ld_ready = (count < LD_DEPTH); combinational from count only.
  - Pointers wrap modulo LD_DEPTH.
  - Push and pop in the same cycle: count unchanged, so a full FIFO cannot push that cycle (ld_ready is already 0).
- Arbitration each cycle (ALU has absolute priority):
  - SEL_ALU: alu_valid=1. Output regs load alu_rd/alu_data; FIFO not popped.
  - SEL_LD: alu_valid=0 and FIFO non-empty. Head popped; output regs load head rd/data.
  - IDLE: otherwise; we<=0, wrAddr/wrData hold.
- Latency:
  - alu_valid at edge N -> we=1 during cycle N+1.
  - Load pushed at edge N into an empty FIFO -> eligible in cycle N+1 -> we=1 in cycle N+2 if no ALU in N+1.
- x0 rule: a selected result with rd==0 is consumed (FIFO popped), but we<=0 that cycle. wrAddr/wrData still update.
- Scoreboard:
  - At each edge, busy[iss_rd] is set if iss_valid && iss_rd!=0.
  - busy[r] is cleared when a write with wrAddr=r is selected that edge (same edge that sets we).
  - Same-edge set and clear of the same r: set wins.
  - busy[0] is constant 0.
- A load starved by back-to-back ALU results stays in the FIFO indefinitely. The FIFO fills and ld_ready drops; this is legal.

Optional Feature:
Macro WB_FORWARD_EN.
- When defined, adds inputs fwd_addr1, fwd_addr2 (AW) and outputs fwd_hit1, fwd_hit2 (1) and fwd_data1, fwd_data2 (XLEN).
- fwd_hitN = we && wrAddr==fwd_addrN && fwd_addrN!=0, combinational; fwd_dataN = wrData.
- The decode stage uses these to bypass the write landing this cycle.
- When undefined, the ports and logic are absent and behaviour is otherwise identical.

Test Plan:
- rst=1 10ns then release -> we=0, wrAddr=0, wrData=0, busy=0, ld_ready=1.
- iss x1; next cycle alu_valid, alu_rd=1, alu_data=32'hDEADBEEF -> busy[1]=1 until the write edge; we=1, wrAddr=1, wrData=DEADBEEF one cycle after alu_valid; busy[1]=0 afterwards.
- ld_valid with rd=2, data=32'h12345678 in the same cycle as alu_valid with rd=3, data=32'hA5A5A5A5 -> write x3 first, then x2 on the next cycle; ld_ready stays 1.
- 4 consecutive ALU cycles while pushing 3 loads -> ld_ready=0 after 2 pushes (DEPTH=2). After the ALU stops, loads retire in push order with no loss or duplication.
- alu_rd=0, data=32'hFFFFFFFF; load with rd=0 -> we never asserts, and the load is still popped (count returns to 0).
- Two loads queued, rst pulsed for 3ns mid-cycle -> immediate we=0 and busy=0; no write of the queued loads after release.
- With WB_FORWARD_EN: fwd_addr1=5 during the cycle we=1, wrAddr=5, wrData=32'hCAFEF00D -> fwd_hit1=1, fwd_data1=CAFEF00D. fwd_addr1=0 -> fwd_hit1=0.
